// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } wait_state_t;

    localparam int REG_AW_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int PERF_W     = 32;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-access wait sequencer: freezes the pipeline for MEM_LAT-1 cycles per
// data-memory instruction sitting in MEM.
module mem_wait_timer
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    output logic mstall,
    output logic mem_busy
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    wait_state_t fsm, fsm_nxt;
    logic [3:0]  cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            cnt <= 4'd0;
        end else begin
            fsm <= fsm_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        cnt_nxt = cnt;
        mstall  = 1'b0;
        case (fsm)
            IDLE: begin
                if (mem_req && (MEM_LAT > 1)) begin
                    mstall  = 1'b1;
                    fsm_nxt = MEM_WAIT;
                    cnt_nxt = LAT_M1;
                end
            end
            MEM_WAIT: begin
                // cnt==1 is the last cycle: the held instruction leaves MEM on
                // this edge, so IDLE next cycle sees the following instruction.
                if (cnt != 4'd1) begin
                    mstall  = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    fsm_nxt = IDLE;
                    cnt_nxt = 4'd0;
                end
            end
            default: begin
                fsm_nxt = IDLE;
                cnt_nxt = 4'd0;
            end
        endcase
    end

    assign mem_busy = (fsm == MEM_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, EX redirect, memory wait).
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              ID_uses_rs,
    input  logic              ID_uses_rt,
    input  logic              EX_memread,
    input  logic              EX_regwrite,
    input  logic [REG_AW-1:0] EX_wraddr,
    input  logic              EX_redirect,
    input  logic              MEM_memread,
    input  logic              MEM_memwrite,
    output logic              pc_stall,
    output logic              IF_ID_stall,
    output logic              IF_ID_flush,
    output logic              ID_EX_stall,
    output logic              ID_EX_flush,
    output logic              EX_MEM_stall,
    output logic              MEM_WB_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_redir,
    output logic [PERF_W-1:0] perf_mwait,
`endif
    output logic              mem_busy
);

    logic mem_req, mstall, busy, lu;
    logic lu_win, redir_win, mwait_win;

    assign mem_req = MEM_memread | MEM_memwrite;

    mem_wait_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_req  (mem_req),
        .mstall   (mstall),
        .mem_busy (busy)
    );

    assign lu = EX_memread && EX_regwrite && (EX_wraddr != REG_AW'(REG_ZERO)) &&
                ((ID_uses_rs && (ID_rs == EX_wraddr)) ||
                 (ID_uses_rt && (ID_rt == EX_wraddr)));

    // Flushes are kept low during mstall: flush beats stall in the pipe regs
    // and would wipe the frozen state; lu/redirect persist and win after release.
    always_comb begin
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_flush = 1'b0;
        lu_win       = 1'b0;
        redir_win    = 1'b0;
        mwait_win    = 1'b0;
        if (rst_n) begin
            if (mstall) begin
                mwait_win    = 1'b1;
                pc_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_stall  = 1'b1;
                EX_MEM_stall = 1'b1;
                MEM_WB_flush = 1'b1;
            end else if (EX_redirect) begin
                redir_win   = 1'b1;
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (lu) begin
                lu_win      = 1'b1;
                pc_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
            end
        end
    end

    assign mem_busy = rst_n & busy;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu    <= '0;
            perf_redir <= '0;
            perf_mwait <= '0;
        end else begin
            if (lu_win && (perf_lu != '1))
                perf_lu <= perf_lu + 1'b1;
            if (redir_win && (perf_redir != '1))
                perf_redir <= perf_redir + 1'b1;
            if (mwait_win && (perf_mwait != '1))
                perf_mwait <= perf_mwait + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances at MEM_LAT 3, 1 and 4 share
// one stimulus bus; outputs are packed {pc,ifid_st,ifid_fl,idex_st,idex_fl,exmem_st,mwb_fl,busy}.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ID_rs, ID_rt, EX_wraddr;
    logic          ID_uses_rs, ID_uses_rt, EX_memread, EX_regwrite, EX_redirect;
    logic          MEM_memread, MEM_memwrite;

    logic [7:0] o3, o1, o4;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] pl3, pr3, pm3, pl1, pr1, pm1, pl4, pr4, pm4;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LAT(3), .REG_AW(AW)) dut3 (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_memread(EX_memread), .EX_regwrite(EX_regwrite), .EX_wraddr(EX_wraddr),
        .EX_redirect(EX_redirect), .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
        .pc_stall(o3[7]), .IF_ID_stall(o3[6]), .IF_ID_flush(o3[5]), .ID_EX_stall(o3[4]),
        .ID_EX_flush(o3[3]), .EX_MEM_stall(o3[2]), .MEM_WB_flush(o3[1]),
`ifdef HAZARD_PERF_CNT_EN
        .perf_lu(pl3), .perf_redir(pr3), .perf_mwait(pm3),
`endif
        .mem_busy(o3[0])
    );

    hazard_ctrl #(.MEM_LAT(1), .REG_AW(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_memread(EX_memread), .EX_regwrite(EX_regwrite), .EX_wraddr(EX_wraddr),
        .EX_redirect(EX_redirect), .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
        .pc_stall(o1[7]), .IF_ID_stall(o1[6]), .IF_ID_flush(o1[5]), .ID_EX_stall(o1[4]),
        .ID_EX_flush(o1[3]), .EX_MEM_stall(o1[2]), .MEM_WB_flush(o1[1]),
`ifdef HAZARD_PERF_CNT_EN
        .perf_lu(pl1), .perf_redir(pr1), .perf_mwait(pm1),
`endif
        .mem_busy(o1[0])
    );

    hazard_ctrl #(.MEM_LAT(4), .REG_AW(AW)) dut4 (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_memread(EX_memread), .EX_regwrite(EX_regwrite), .EX_wraddr(EX_wraddr),
        .EX_redirect(EX_redirect), .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
        .pc_stall(o4[7]), .IF_ID_stall(o4[6]), .IF_ID_flush(o4[5]), .ID_EX_stall(o4[4]),
        .ID_EX_flush(o4[3]), .EX_MEM_stall(o4[2]), .MEM_WB_flush(o4[1]),
`ifdef HAZARD_PERF_CNT_EN
        .perf_lu(pl4), .perf_redir(pr4), .perf_mwait(pm4),
`endif
        .mem_busy(o4[0])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        ID_rs = '0; ID_rt = '0; EX_wraddr = '0;
        ID_uses_rs = 0; ID_uses_rt = 0; EX_memread = 0; EX_regwrite = 0;
        EX_redirect = 0; MEM_memread = 0; MEM_memwrite = 0;
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        #1;
    endtask

    initial begin
        clr_in();
        rst_n = 0;
        #1;
        chk("rst_o3", 32'(o3), 32'h00);
        chk("rst_o4", 32'(o4), 32'h00);
        tick();
        rst_n = 1;
        #1;
        chk("idle_o3", 32'(o3), 32'h00);

        // 1: MEM_LAT=3, then a back-to-back second access
        MEM_memread = 1; #1;
        chk("t1_c0", 32'(o3), 32'hD6);
        tick(); chk("t1_c1", 32'(o3), 32'hD7);
        tick(); chk("t1_c2_rel", 32'(o3), 32'h01);
        tick(); chk("t1_b2b_c0", 32'(o3), 32'hD6);
        tick(); chk("t1_b2b_c1", 32'(o3), 32'hD7);
        tick(); chk("t1_b2b_rel", 32'(o3), 32'h01);
        tick(); MEM_memread = 0; #1;
        chk("t1_idle", 32'(o3), 32'h00);

        // 2: MEM_LAT=1 never waits
        do_reset();
        MEM_memwrite = 1;
        for (int i = 0; i < 4; i++) begin
            #1; chk("t2_lat1", 32'(o1), 32'h00);
            tick();
        end
        do_reset();

        // 3: load-use on rt, then on rs, then r0 and non-reading cases
        EX_memread = 1; EX_regwrite = 1; EX_wraddr = 5; ID_uses_rt = 1; ID_rt = 5; #1;
        chk("t3_lu_rt", 32'(o3), 32'hC8);
        EX_wraddr = 0; ID_rt = 0; #1;
        chk("t3_r0", 32'(o3), 32'h00);
        ID_uses_rt = 0; ID_uses_rs = 1; ID_rs = 7; EX_wraddr = 7; #1;
        chk("t3_lu_rs", 32'(o3), 32'hC8);
        ID_uses_rs = 0; #1;
        chk("t3_no_use", 32'(o3), 32'h00);
        ID_uses_rs = 1; EX_regwrite = 0; #1;
        chk("t3_no_wr", 32'(o3), 32'h00);
        EX_regwrite = 1;

        // 4: redirect beats load-use
        EX_redirect = 1; #1;
        chk("t4_redir", 32'(o3), 32'h28);
        do_reset();

        // 5: MEM_LAT=4 with redirect pending during the wait
        MEM_memread = 1; EX_redirect = 1; #1;
        chk("t5_c0", 32'(o4), 32'hD6);
        tick(); chk("t5_c1", 32'(o4), 32'hD7);
        tick(); chk("t5_c2", 32'(o4), 32'hD7);
        tick(); chk("t5_rel", 32'(o4), 32'h29);
        tick(); MEM_memread = 0; EX_redirect = 0; #1;
        chk("t5_done", 32'(o4), 32'h00);
        do_reset();

        // 6: reset asserted in MEM_WAIT with cnt=2
        MEM_memread = 1; EX_redirect = 1;
        EX_memread = 1; EX_regwrite = 1; EX_wraddr = 3; ID_uses_rs = 1; ID_rs = 3;
        tick(); tick();
        chk("t6_wait", 32'(o4), 32'hD7);
        rst_n = 0; #1;
        chk("t6_rst_o4", 32'(o4), 32'h00);
        chk("t6_rst_o3", 32'(o3), 32'h00);
        clr_in();
        tick();
        rst_n = 1; #1;
        chk("t6_post", 32'(o4), 32'h00);
        tick();
        chk("t6_post2", 32'(o4), 32'h00);
`ifdef HAZARD_PERF_CNT_EN
        chk("t6_pl4", pl4, 32'h0);
        chk("t6_pr4", pr4, 32'h0);
        chk("t6_pm4", pm4, 32'h0);
        chk("t6_pm3", pm3, 32'h0);
        chk("t6_pl1", pl1 | pr1 | pm1 | pl3 | pr3, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall/flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the PC hold.
- Resolves three hazards: load-use, EX-stage control redirect, and multi-cycle data-memory access.
- The memory-wait sequencing is a small FSM with a down-counter.

Parameters:
- MEM_LAT, 2: data-memory access latency in cycles, legal 1..15; 1 means single-cycle, never waits.
- REG_AW, 5: register-address width.

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- ID_rs  in  REG_AW  source register rs of the instruction in ID
- ID_rt  in  REG_AW  source register rt of the instruction in ID
- ID_uses_rs  in  1  ID instruction reads rs
- ID_uses_rt  in  1  ID instruction reads rt
- EX_memread  in  1  EX instruction is a load
- EX_regwrite  in  1  EX instruction writes a register
- EX_wraddr  in  REG_AW  EX destination register
- EX_redirect  in  1  taken branch/jump resolved in EX
- MEM_memread  in  1  MEM instruction reads data memory
- MEM_memwrite  in  1  MEM instruction writes data memory
- pc_stall  out  1  hold PC
- IF_ID_stall  out  1  hold IF_ID register
- IF_ID_flush  out  1  load NOP into IF_ID
- ID_EX_stall  out  1  hold ID_EX register
- ID_EX_flush  out  1  load NOP into ID_EX
- EX_MEM_stall  out  1  hold EX_MEM register
- MEM_WB_flush  out  1  load bubble into MEM_WB
- mem_busy  out  1  FSM is in MEM_WAIT

Behaviour:
- State: fsm in {IDLE, MEM_WAIT}; cnt 4 bits.
- Reset: fsm=IDLE, cnt=0.
- While rst_n=0, every output is forced to 0, combinationally.
- Reset asserted mid-wait returns to IDLE with no residual stall after release.
- mem_req = MEM_memread | MEM_memwrite.
- Memory wait: mstall = (IDLE & mem_req & MEM_LAT>1) | (MEM_WAIT & cnt!=1).
- Transitions:
  - IDLE & mem_req & MEM_LAT>1 -> MEM_WAIT, cnt=MEM_LAT-1.
  - MEM_WAIT & cnt!=1 -> cnt-1.
  - MEM_WAIT & cnt==1 -> IDLE; the held instruction advances on this edge, so it is never re-triggered.
  - Result: a memory instruction occupies MEM for exactly MEM_LAT cycles, i.e. MEM_LAT-1 stall cycles.
  - Back-to-back memory instructions each get a full wait; IDLE in the cycle after release samples the new MEM instruction.
- Load-use: lu = EX_memread & EX_regwrite & EX_wraddr!=0 & ((ID_uses_rs & ID_rs==EX_wraddr) | (ID_uses_rt & ID_rt==EX_wraddr)). This costs 1 bubble; MEM-to-EX forwarding covers the rest.
- Priority, combinational, same cycle:
  1. mstall: pc_stall=IF_ID_stall=ID_EX_stall=EX_MEM_stall=1, MEM_WB_flush=1. All other flushes are 0, because flush beats stall in the pipeline registers and would destroy held state. lu and EX_redirect are ignored while mstall=1; they stay asserted because EX is frozen, and are honoured after release.
  2. EX_redirect: IF_ID_flush=1, ID_EX_flush=1, no stalls. The wrong-path instruction in ID suppresses lu.
  3. lu: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1.
  4. Otherwise all outputs 0.
- mem_busy = (fsm==MEM_WAIT).
- Outputs are combinational from fsm/cnt and inputs; zero-cycle latency to the pipeline registers.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Three 32-bit saturating counters, cleared by reset.
  - lu_cnt counts cycles where load-use wins arbitration; redir_cnt counts winning EX_redirect cycles; mwait_cnt counts mstall cycles.
  - Exposed as outputs perf_lu, perf_redir, perf_mwait, each 32 bits.
  - Counters hold at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds: the state enum (IDLE, MEM_WAIT), REG_AW default, REG_ZERO constant, and the 32-bit perf-counter width.
- One sub-module, mem_wait_timer, holds fsm+cnt and outputs mstall and mem_busy. It is parameterized by MEM_LAT.
- The hazard decode and priority mux stay in hazard_ctrl.

Test Plan:
1. MEM_LAT=3; MEM_memread pulse held by stall:
   - Expect mstall/EX_MEM_stall/MEM_WB_flush=1 for exactly 2 cycles, mem_busy=1 for 2 cycles.
   - Then all 0 and fsm=IDLE.
2. MEM_LAT=1; continuous MEM_memwrite: all outputs stay 0, mem_busy never 1.
3. EX_memread=1, EX_regwrite=1, EX_wraddr=5, ID_uses_rt=1, ID_rt=5:
   - Expect pc_stall=IF_ID_stall=ID_EX_flush=1.
   - Repeat with EX_wraddr=0: all 0.
4. Load-use condition plus EX_redirect=1 in the same cycle: IF_ID_flush=ID_EX_flush=1, pc_stall=0.
5. MEM_LAT=4; EX_redirect=1 during the wait:
   - Flushes stay 0 for all 3 stall cycles.
   - Flushes assert in the cycle after release.
6. rst_n driven low in MEM_WAIT with cnt=2:
   - Outputs are 0 immediately.
   - After release with mem_req=0, fsm=IDLE and no stall.
   - With HAZARD_PERF_CNT_EN defined, all perf counters read 0.
